alu_sequencer: RTL and testbench

Multi-cycle controller that turns a 6502 arithmetic/logic request into one or more passes through the combinational 5-function ALU (ADD/SR/AND/OR/XOR) and returns the result with N/Z/C/V flags. It sits between instruction decode and the ALU, and owns the ALU's control and operand inputs. It synthesises SBC, CMP, shifts, rotates, INC/DEC and BCD ADC/SBC from the ALU primitives. Requests and results use valid/ready handshakes.

---
 rtl/alu_sequencer.sv | 279 +++++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle 6502 arithmetic/logic sequencer around a 5-function ALU
// Purpose: turns one 6502 ALU request into one ALU pass (binary ops) or four
//   registered nibble passes (BCD ADC/SBC) and returns the byte plus N/Z/C/V.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   op_valid/op_ready               request handshake (ready only in IDLE)
//   op_code, op_a, op_b, op_c, op_d operation, operands, carry in, decimal flag
//   res_valid/res_ready             result handshake (held in DONE)
//   res_y, res_n/z/c/v              result byte and flags
//   res_mask, res_wr, res_err       {N,Z,C,V} update enables, write-back, illegal op
//   alu_control, alu_AI, alu_BI, alu_carry_in        drive to the ALU
//   alu_Y, alu_carry_out, alu_overflow               ALU results
module alu_sequencer #(
  parameter bit DECIMAL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [3:0] op_code,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic       op_c,
  input  logic       op_d,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_y,
  output logic       res_n,
  output logic       res_z,
  output logic       res_c,
  output logic       res_v,
  output logic [3:0] res_mask,
  output logic       res_wr,
  output logic       res_err,
  output logic [2:0] alu_control,
  output logic [7:0] alu_AI,
  output logic [7:0] alu_BI,
  output logic       alu_carry_in,
  input  logic [7:0] alu_Y,
  input  logic       alu_carry_out,
  input  logic       alu_overflow
);

  localparam logic [2:0] S_IDLE = 3'd0, S_EXEC = 3'd1, S_DONE = 3'd2, S_D_LO = 3'd3,
                         S_D_LOADJ = 3'd4, S_D_HI = 3'd5, S_D_HIADJ = 3'd6;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SR = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3,
                         ALU_XOR = 3'd4;
  localparam logic [3:0] OP_ADC = 4'h0, OP_SBC = 4'h1, OP_AND = 4'h2, OP_ORA = 4'h3,
                         OP_EOR = 4'h4, OP_ASL = 4'h5, OP_ROL = 4'h6, OP_LSR = 4'h7,
                         OP_ROR = 4'h8, OP_CMP = 4'h9, OP_INC = 4'hA, OP_DEC = 4'hB;

  logic [2:0] state_q, state_d;
  logic [3:0] code_q, code_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic       c_q, c_d;
  logic [4:0] ls_q, ls_d, hs_q, hs_d;
  logic [3:0] lo_q, lo_d;
  logic       half_q, half_d;
  logic [7:0] y_q, y_d;
  logic       n_q, n_d, z_q, z_d, rc_q, rc_d, v_q, v_d;
  logic [3:0] mask_q, mask_d;
  logic       wr_q, wr_d, err_q, err_d;

  logic       is_sbc;
  logic [7:0] k;

  assign is_sbc = (code_q == OP_SBC);
  // SBC is A + ~B + C, so the decimal passes add the complemented B nibbles.
  assign k = is_sbc ? ~b_q : b_q;

  // ADC corrects a nibble sum above 9 by +6; SBC corrects a borrow
  // (no carry out of bit 3) by +A, which is -6 modulo 16.
  function automatic logic [7:0] bcd_adj(input logic sbc, input logic [4:0] v);
    if (sbc) return v[4] ? 8'h00 : 8'h0A;
    else     return (v > 5'd9) ? 8'h06 : 8'h00;
  endfunction

  function automatic logic bcd_carry(input logic sbc, input logic [4:0] v);
    return sbc ? v[4] : (v > 5'd9);
  endfunction

  always_comb begin
    alu_control  = ALU_AND;
    alu_AI       = 8'h00;
    alu_BI       = 8'h00;
    alu_carry_in = 1'b0;
    case (state_q)
      S_EXEC: begin
        alu_AI = a_q;
        case (code_q)
          OP_ADC: begin alu_control = ALU_ADD; alu_BI = b_q;  alu_carry_in = c_q;  end
          OP_SBC: begin alu_control = ALU_ADD; alu_BI = ~b_q; alu_carry_in = c_q;  end
          OP_AND: begin alu_control = ALU_AND; alu_BI = b_q;  end
          OP_ORA: begin alu_control = ALU_OR;  alu_BI = b_q;  end
          OP_EOR: begin alu_control = ALU_XOR; alu_BI = b_q;  end
          OP_ASL: begin alu_control = ALU_ADD; alu_BI = a_q;  end
          OP_ROL: begin alu_control = ALU_ADD; alu_BI = a_q;  alu_carry_in = c_q;  end
          OP_LSR: begin alu_control = ALU_SR;  end
          OP_ROR: begin alu_control = ALU_SR;  alu_carry_in = c_q;  end
          OP_CMP: begin alu_control = ALU_ADD; alu_BI = ~b_q; alu_carry_in = 1'b1; end
          OP_INC: begin alu_control = ALU_ADD; alu_carry_in = 1'b1; end
          OP_DEC: begin alu_control = ALU_ADD; alu_BI = 8'hFF; end
          default: alu_AI = 8'h00;
        endcase
      end
      S_D_LO: begin
        alu_control  = ALU_ADD;
        alu_AI       = {4'h0, a_q[3:0]};
        alu_BI       = {4'h0, k[3:0]};
        alu_carry_in = c_q;
      end
      S_D_LOADJ: begin
        alu_control = ALU_ADD;
        alu_AI      = {3'b000, ls_q};
        alu_BI      = bcd_adj(is_sbc, ls_q);
      end
      S_D_HI: begin
        alu_control  = ALU_ADD;
        alu_AI       = {4'h0, a_q[7:4]};
        alu_BI       = {4'h0, k[7:4]};
        alu_carry_in = half_q;
      end
      S_D_HIADJ: begin
        alu_control = ALU_ADD;
        alu_AI      = {3'b000, hs_q};
        alu_BI      = bcd_adj(is_sbc, hs_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    ls_d    = ls_q;
    hs_d    = hs_q;
    lo_d    = lo_q;
    half_d  = half_q;
    y_d     = y_q;
    n_d     = n_q;
    z_d     = z_q;
    rc_d    = rc_q;
    v_d     = v_q;
    mask_d  = mask_q;
    wr_d    = wr_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          code_d  = op_code;
          a_d     = op_a;
          b_d     = op_b;
          c_d     = op_c;
          state_d = (op_d && DECIMAL_EN && (op_code == OP_ADC || op_code == OP_SBC))
                    ? S_D_LO : S_EXEC;
        end
      end
      S_EXEC: begin
        y_d     = alu_Y;
        n_d     = alu_Y[7];
        z_d     = (alu_Y == 8'h00);
        rc_d    = alu_carry_out;
        v_d     = 1'b0;
        wr_d    = 1'b1;
        err_d   = 1'b0;
        mask_d  = 4'b1110;
        state_d = S_DONE;
        case (code_q)
          OP_ADC, OP_SBC: begin
            v_d    = alu_overflow;
            mask_d = 4'b1111;
          end
          OP_AND, OP_ORA, OP_EOR, OP_INC, OP_DEC: begin
            rc_d   = c_q;
            mask_d = 4'b1100;
          end
          OP_ASL, OP_ROL, OP_LSR, OP_ROR: ;
          // CMP reports flags of the difference but leaves the byte as A.
          OP_CMP: begin
            y_d  = a_q;
            wr_d = 1'b0;
          end
          default: begin
            y_d    = a_q;
            n_d    = a_q[7];
            z_d    = (a_q == 8'h00);
            rc_d   = c_q;
            mask_d = 4'b0000;
            wr_d   = 1'b0;
            err_d  = 1'b1;
          end
        endcase
      end
      S_D_LO: begin
        ls_d    = alu_Y[4:0];
        state_d = S_D_LOADJ;
      end
      S_D_LOADJ: begin
        lo_d    = alu_Y[3:0];
        half_d  = bcd_carry(is_sbc, ls_q);
        state_d = S_D_HI;
      end
      S_D_HI: begin
        hs_d    = alu_Y[4:0];
        state_d = S_D_HIADJ;
      end
      S_D_HIADJ: begin
        y_d     = {alu_Y[3:0], lo_q};
        n_d     = alu_Y[3];
        z_d     = ({alu_Y[3:0], lo_q} == 8'h00);
        rc_d    = bcd_carry(is_sbc, hs_q);
        v_d     = 1'b0;
        mask_d  = 4'b1110;
        wr_d    = 1'b1;
        err_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      code_q  <= 4'h0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      c_q     <= 1'b0;
      ls_q    <= 5'd0;
      hs_q    <= 5'd0;
      lo_q    <= 4'h0;
      half_q  <= 1'b0;
      y_q     <= 8'h00;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      rc_q    <= 1'b0;
      v_q     <= 1'b0;
      mask_q  <= 4'h0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      ls_q    <= ls_d;
      hs_q    <= hs_d;
      lo_q    <= lo_d;
      half_q  <= half_d;
      y_q     <= y_d;
      n_q     <= n_d;
      z_q     <= z_d;
      rc_q    <= rc_d;
      v_q     <= v_d;
      mask_q  <= mask_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  assign op_ready  = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign res_y     = y_q;
  assign res_n     = n_q;
  assign res_z     = z_q;
  assign res_c     = rc_q;
  assign res_v     = v_q;
  assign res_mask  = mask_q;
  assign res_wr    = wr_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid, op_ready, op_c, op_d;
  logic [3:0] op_code;
  logic [7:0] op_a, op_b;
  logic       res_valid, res_ready, res_n, res_z, res_c, res_v, res_wr, res_err;
  logic [7:0] res_y;
  logic [3:0] res_mask;
  logic [2:0] alu_control;
  logic [7:0] alu_AI, alu_BI, alu_Y;
  logic       alu_carry_in, alu_carry_out, alu_overflow;

  logic       op_valid0, op_ready0, res_valid0, res_ready0;
  logic       res_n0, res_z0, res_c0, res_v0, res_wr0, res_err0;
  logic [7:0] res_y0;
  logic [3:0] res_mask0;
  logic [2:0] alu_control0;
  logic [7:0] alu_AI0, alu_BI0, alu_Y0;
  logic       alu_carry_in0, alu_carry_out0, alu_overflow0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.DECIMAL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
    .res_n(res_n), .res_z(res_z), .res_c(res_c), .res_v(res_v),
    .res_mask(res_mask), .res_wr(res_wr), .res_err(res_err),
    .alu_control(alu_control), .alu_AI(alu_AI), .alu_BI(alu_BI),
    .alu_carry_in(alu_carry_in), .alu_Y(alu_Y),
    .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow)
  );

  alu_sequencer #(.DECIMAL_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .op_valid(op_valid0), .op_ready(op_ready0),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
    .res_valid(res_valid0), .res_ready(res_ready0), .res_y(res_y0),
    .res_n(res_n0), .res_z(res_z0), .res_c(res_c0), .res_v(res_v0),
    .res_mask(res_mask0), .res_wr(res_wr0), .res_err(res_err0),
    .alu_control(alu_control0), .alu_AI(alu_AI0), .alu_BI(alu_BI0),
    .alu_carry_in(alu_carry_in0), .alu_Y(alu_Y0),
    .alu_carry_out(alu_carry_out0), .alu_overflow(alu_overflow0)
  );

  // Combinational 5-function ALU: returns {carry_out, overflow, Y}.
  function automatic logic [9:0] alu_f(input logic [2:0] ctl, input logic [7:0] ai,
                                       input logic [7:0] bi, input logic ci);
    logic [8:0] s;
    case (ctl)
      3'd0: begin
        s = {1'b0, ai} + {1'b0, bi} + {8'h00, ci};
        return {s[8], (ai[7] == bi[7]) && (s[7] != ai[7]), s[7:0]};
      end
      3'd1: return {ai[0], 1'b0, ci, ai[7:1]};
      3'd2: return {2'b00, ai & bi};
      3'd3: return {2'b00, ai | bi};
      3'd4: return {2'b00, ai ^ bi};
      default: return 10'h000;
    endcase
  endfunction

  always_comb {alu_carry_out, alu_overflow, alu_Y} = alu_f(alu_control, alu_AI, alu_BI, alu_carry_in);
  always_comb {alu_carry_out0, alu_overflow0, alu_Y0} = alu_f(alu_control0, alu_AI0, alu_BI0, alu_carry_in0);

  // Expected result and ALU pass sequence for the current request.
  logic [7:0] e_y;
  logic       e_n, e_z, e_c, e_v, e_wr, e_err;
  logic [3:0] e_mask;
  int         npass;
  logic [3:0] p_care [4];
  logic [2:0] p_ctl  [4];
  logic [7:0] p_ai   [4];
  logic [7:0] p_bi   [4];
  logic       p_cin  [4];
  logic [3:0] cur_code;

  logic [7:0] got_y;
  logic [3:0] got_f, got_mask;
  logic       got_wr, got_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s op=%0h actual=%0h required=%0h", nm, cur_code, act, req);
    end
  endtask

  task automatic setp(input int i, input logic [3:0] care, input logic [2:0] ctl,
                      input logic [7:0] ai, input logic [7:0] bi, input logic ci);
    p_care[i] = care; p_ctl[i] = ctl; p_ai[i] = ai; p_bi[i] = bi; p_cin[i] = ci;
  endtask

  task automatic model(input logic [3:0] code, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic d);
    logic [8:0] s;
    logic [7:0] kb, df;
    logic       sbc, half;
    int         ls, hs, ladj, hadj;
    cur_code = code;
    e_err = 1'b0; e_wr = 1'b1; e_v = 1'b0; e_c = c; e_mask = 4'b1100; npass = 1;
    kb = ~b;
    df = a - b;
    case (code)
      4'h0: begin s = {1'b0, a} + {1'b0, b} + {8'h00, c}; e_y = s[7:0]; e_c = s[8];
                  e_v = (a[7] == b[7]) && (e_y[7] != a[7]); e_mask = 4'hF; setp(0, 4'hF, 3'd0, a, b, c); end
      4'h1: begin s = {1'b0, a} + {1'b0, kb} + {8'h00, c}; e_y = s[7:0]; e_c = s[8];
                  e_v = (a[7] != b[7]) && (e_y[7] != a[7]); e_mask = 4'hF; setp(0, 4'hF, 3'd0, a, kb, c); end
      4'h2: begin e_y = a & b; setp(0, 4'b1110, 3'd2, a, b, 1'b0); end
      4'h3: begin e_y = a | b; setp(0, 4'b1110, 3'd3, a, b, 1'b0); end
      4'h4: begin e_y = a ^ b; setp(0, 4'b1110, 3'd4, a, b, 1'b0); end
      4'h5: begin e_y = {a[6:0], 1'b0}; e_c = a[7]; e_mask = 4'hE; setp(0, 4'hF, 3'd0, a, a, 1'b0); end
      4'h6: begin e_y = {a[6:0], c}; e_c = a[7]; e_mask = 4'hE; setp(0, 4'hF, 3'd0, a, a, c); end
      4'h7: begin e_y = {1'b0, a[7:1]}; e_c = a[0]; e_mask = 4'hE; setp(0, 4'b1101, 3'd1, a, 8'h00, 1'b0); end
      4'h8: begin e_y = {c, a[7:1]}; e_c = a[0]; e_mask = 4'hE; setp(0, 4'b1101, 3'd1, a, 8'h00, c); end
      4'h9: begin e_y = a; e_c = (a >= b); e_wr = 1'b0; e_mask = 4'hE; setp(0, 4'hF, 3'd0, a, kb, 1'b1); end
      4'hA: begin e_y = a + 8'd1; setp(0, 4'hF, 3'd0, a, 8'h00, 1'b1); end
      4'hB: begin e_y = a - 8'd1; setp(0, 4'hF, 3'd0, a, 8'hFF, 1'b0); end
      default: begin e_y = a; e_err = 1'b1; e_wr = 1'b0; e_mask = 4'h0; setp(0, 4'h0, 3'd0, 8'h00, 8'h00, 1'b0); end
    endcase
    if (d && code <= 4'h1) begin
      sbc  = (code == 4'h1);
      if (!sbc) kb = b;
      ls   = int'(a[3:0]) + int'(kb[3:0]) + int'(c);
      half = sbc ? (ls >= 16) : (ls > 9);
      ladj = sbc ? (half ? 0 : 10) : (half ? 6 : 0);
      hs   = int'(a[7:4]) + int'(kb[7:4]) + int'(half);
      e_c  = sbc ? (hs >= 16) : (hs > 9);
      hadj = sbc ? (e_c ? 0 : 10) : (e_c ? 6 : 0);
      e_y  = 8'((((hs + hadj) % 16) * 16) + ((ls + ladj) % 16));
      e_v = 1'b0; e_mask = 4'hE; npass = 4;
      setp(0, 4'hF, 3'd0, {4'h0, a[3:0]}, {4'h0, kb[3:0]}, c);
      setp(1, 4'hF, 3'd0, 8'(ls), 8'(ladj), 1'b0);
      setp(2, 4'hF, 3'd0, {4'h0, a[7:4]}, {4'h0, kb[7:4]}, half);
      setp(3, 4'hF, 3'd0, 8'(hs), 8'(hadj), 1'b0);
    end
    e_n = e_y[7];
    e_z = (e_y == 8'h00);
    if (code == 4'h9) begin e_n = df[7]; e_z = (df == 8'h00); end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_alu"}, {alu_control, alu_AI, alu_BI, alu_carry_in}, {3'd2, 8'h00, 8'h00, 1'b0});
  endtask

  task automatic chk_res(input string nm);
    chk({nm, "_valid"}, res_valid, 1'b1);
    chk({nm, "_y"}, res_y, e_y);
    chk({nm, "_nzcv"}, {res_n, res_z, res_c, res_v}, {e_n, e_z, e_c, e_v});
    chk({nm, "_mask"}, res_mask, e_mask);
    chk({nm, "_wr_err"}, {res_wr, res_err}, {e_wr, e_err});
    chk({nm, "_op_ready"}, op_ready, 1'b0);
  endtask

  // Entered and left #1 after a rising edge with the DUT idle.
  task automatic run_op(input logic [3:0] code, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic d, input int hold);
    model(code, a, b, c, d);
    chk("accept_ready", op_ready, 1'b1);
    op_code = code; op_a = a; op_b = b; op_c = c; op_d = d; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    op_code = 4'($urandom); op_a = 8'($urandom); op_b = 8'($urandom);
    op_c = 1'($urandom); op_d = 1'($urandom);
    for (int i = 0; i < npass; i++) begin
      chk("busy_valid_ready", {res_valid, op_ready}, 2'b00);
      if (p_care[i][3]) chk("pass_ctl", alu_control, p_ctl[i]);
      if (p_care[i][2]) chk("pass_ai", alu_AI, p_ai[i]);
      if (p_care[i][1]) chk("pass_bi", alu_BI, p_bi[i]);
      if (p_care[i][0]) chk("pass_cin", alu_carry_in, p_cin[i]);
      @(posedge clk); #1;
    end
    chk_res("done");
    chk_idle("done");
    got_y = res_y; got_f = {res_n, res_z, res_c, res_v}; got_mask = res_mask;
    got_wr = res_wr; got_err = res_err;
    for (int h = 0; h < hold; h++) begin
      op_valid = 1'($urandom);
      @(posedge clk); #1;
      chk_res("hold");
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("release", {res_valid, op_ready}, 2'b01);
    chk_idle("idle");
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; res_ready = 1'b0; op_valid0 = 1'b0; res_ready0 = 1'b0;
    op_code = 4'h0; op_a = 8'h00; op_b = 8'h00; op_c = 1'b0; op_d = 1'b0; cur_code = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_ready", {res_valid, op_ready}, 2'b01);
    chk("rst_res", {res_y, res_n, res_z, res_c, res_v, res_mask, res_wr, res_err}, 18'h0);
    chk_idle("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(4'h0, 8'h50, 8'h50, 1'b0, 1'b0, 0);
    chk("t1", {got_y, got_f, got_mask}, {8'hA0, 4'b1001, 4'hF});
    run_op(4'h1, 8'h00, 8'h01, 1'b1, 1'b0, 0);
    chk("t2", {got_y, got_f}, {8'hFF, 4'b1000});
    run_op(4'h0, 8'h58, 8'h46, 1'b1, 1'b1, 0);
    chk("t3", {got_y, got_f, got_mask}, {8'h05, 4'b0010, 4'hE});
    run_op(4'h1, 8'h12, 8'h21, 1'b1, 1'b1, 0);
    chk("t4a", {got_y, got_f[3], got_f[1]}, {8'h91, 1'b1, 1'b0});
    run_op(4'h1, 8'h46, 8'h12, 1'b1, 1'b1, 0);
    chk("t4b", {got_y, got_f[1]}, {8'h34, 1'b1});
    run_op(4'h9, 8'h40, 8'h40, 1'b0, 1'b0, 0);
    chk("t5_cmp", {got_y, got_f, got_wr, got_mask}, {8'h40, 4'b0110, 1'b0, 4'hE});
    run_op(4'h8, 8'h01, 8'h00, 1'b1, 1'b0, 0);
    chk("t5_ror", {got_y, got_f}, {8'h80, 4'b1010});
    run_op(4'hF, 8'h3C, 8'h11, 1'b0, 1'b0, 0);
    chk("t5_ill", {got_err, got_mask, got_y}, {1'b1, 4'h0, 8'h3C});
    run_op(4'h2, 8'hF0, 8'h3C, 1'b1, 1'b0, 5);
    chk("t6_hold", {got_y, got_mask}, {8'h30, 4'hC});

    // Decimal flag ignored when DECIMAL_EN=0: binary result, 2-cycle latency.
    cur_code = 4'h1;
    op_code = 4'h1; op_a = 8'h00; op_b = 8'h01; op_c = 1'b1; op_d = 1'b1; op_valid0 = 1'b1;
    chk("d0_ready", op_ready0, 1'b1);
    @(posedge clk); #1;
    op_valid0 = 1'b0;
    chk("d0_early", res_valid0, 1'b0);
    @(posedge clk); #1;
    chk("d0_sbc", {res_valid0, res_y0, res_n0, res_z0, res_c0, res_v0, res_mask0},
        {1'b1, 8'hFF, 4'b1000, 4'hF});
    res_ready0 = 1'b1;
    @(posedge clk); #1;
    res_ready0 = 1'b0;
    cur_code = 4'h0;
    op_code = 4'h0; op_a = 8'h58; op_b = 8'h46; op_c = 1'b1; op_d = 1'b1; op_valid0 = 1'b1;
    @(posedge clk); #1;
    op_valid0 = 1'b0;
    @(posedge clk); #1;
    chk("d0_adc", {res_valid0, res_y0, res_n0, res_z0, res_c0, res_v0}, {1'b1, 8'h9F, 4'b1001});
    res_ready0 = 1'b1;
    @(posedge clk); #1;
    res_ready0 = 1'b0;
    chk("d0_release", op_ready0, 1'b1);

    // Reset while the high-nibble pass is in flight.
    op_code = 4'h0; op_a = 8'h58; op_b = 8'h46; op_c = 1'b1; op_d = 1'b1; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_mid_pos", {alu_control, alu_AI, alu_BI}, {3'd0, 8'h05, 8'h04});
    reset = 1'b1;
    #1;
    chk("rst_mid_valid_ready", {res_valid, op_ready}, 2'b01);
    chk("rst_mid_res", {res_y, res_n, res_z, res_c, res_v, res_mask, res_wr, res_err}, 18'h0);
    chk_idle("rst_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(4'h0, 8'h27, 8'h35, 1'b0, 1'b1, 0);
    chk("after_rst", {got_y, got_f[1]}, {8'h62, 1'b0});

    for (int t = 0; t < 200; t++)
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom),
             1'($urandom), int'($urandom_range(0, 3)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
